// File: rtl/echo_pkg.sv
// rtl/echo_pkg.sv - shared types and constants for the echo mixer
package echo_pkg;

  typedef enum logic [1:0] {FILL, RAMP, RUN} echo_state_t;

  localparam int MIDSCALE   = 128;
  localparam int RAMP_STEPS = 8;
  localparam int SAT_MAX    = 127;
  localparam int SAT_MIN    = -128;

endpackage

// File: rtl/echo_mixer_if.sv
// rtl/echo_mixer_if.sv - sample stream bundle between delay stage, mixer and DAC path
interface echo_mixer_if #(
  parameter int DATA_W = 8
);
  logic              en;
  logic [DATA_W-1:0] mic_signal;
  logic [DATA_W-1:0] delayed_signal;
  logic [DATA_W-1:0] mix_out;
  logic              out_valid;

  modport master (output en, mic_signal, delayed_signal, input mix_out, out_valid);
  modport slave  (input en, mic_signal, delayed_signal, output mix_out, out_valid);
endinterface

// File: rtl/echo_ramp_ctrl.sv
// rtl/echo_ramp_ctrl.sv - fill/ramp FSM muting stale delay-line data and fading the echo in
module echo_ramp_ctrl
  import echo_pkg::*;
#(
  parameter int ADDR_W    = 9,
  parameter int RAMP_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [ADDR_W-1:0] offset,
  output logic [3:0]        ramp_k,
  output logic              echo_active
);

  echo_state_t          state, state_nxt;
  logic [ADDR_W-1:0]    fill_cnt, fill_nxt, fill_inc;
  logic [RAMP_LOG2-1:0] sub_cnt, sub_nxt;
  logic [3:0]           ramp_k_nxt;
  logic [ADDR_W-1:0]    offset_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FILL;
      fill_cnt <= '0;
      sub_cnt  <= '0;
      ramp_k   <= '0;
      offset_q <= '0;
    end else begin
      state    <= state_nxt;
      fill_cnt <= fill_nxt;
      sub_cnt  <= sub_nxt;
      ramp_k   <= ramp_k_nxt;
      offset_q <= offset;
    end
  end

  always_comb begin
    state_nxt  = state;
    fill_nxt   = fill_cnt;
    sub_nxt    = sub_cnt;
    ramp_k_nxt = ramp_k;
    fill_inc   = (fill_cnt == '1) ? fill_cnt : fill_cnt + 1'b1;
    // A retune invalidates the whole delay line, so it overrides everything, even without en.
    if (offset != offset_q) begin
      state_nxt  = FILL;
      fill_nxt   = '0;
      sub_nxt    = '0;
      ramp_k_nxt = '0;
    end else if (en) begin
      case (state)
        FILL: begin
          ramp_k_nxt = '0;
          sub_nxt    = '0;
          if (fill_cnt == offset) begin
            state_nxt = RAMP;
          end else begin
            fill_nxt = fill_inc;
            if (fill_inc == offset) state_nxt = RAMP;
          end
        end
        RAMP: begin
          if (sub_cnt == '1) begin
            sub_nxt    = '0;
            ramp_k_nxt = ramp_k + 4'd1;
            if (ramp_k == 4'(RAMP_STEPS - 1)) state_nxt = RUN;
          end else begin
            sub_nxt = sub_cnt + 1'b1;
          end
        end
        RUN:     ramp_k_nxt = 4'(RAMP_STEPS);
        default: state_nxt  = FILL;
      endcase
    end
  end

  assign echo_active = (state != FILL);

endmodule

// File: rtl/echo_mixer.sv
// rtl/echo_mixer.sv - mixes live mic with delayed sample: ramped gain, extra attenuation, saturation
module echo_mixer
  import echo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 9,
  parameter int RAMP_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst,
  echo_mixer_if.slave       io,
  input  logic [ADDR_W-1:0] offset,
  input  logic [1:0]        mix_gain,
  input  logic              bypass,
  output logic              echo_active
);

  localparam int W = DATA_W + 5;
  localparam logic signed [W-1:0] HI = W'(SAT_MAX);
  localparam logic signed [W-1:0] LO = W'(SAT_MIN);

  logic [3:0]        ramp_k, k_q;
  logic [DATA_W-1:0] mic_q, mix_q, mix_nxt;
  logic              en_d1, valid_q;

  logic signed [DATA_W:0] s, e;
  logic signed [W-1:0]    e_x, k_x, prod, t, sum;

  echo_ramp_ctrl #(
    .ADDR_W    (ADDR_W),
    .RAMP_LOG2 (RAMP_LOG2)
  ) u_ramp (
    .clk         (clk),
    .rst         (rst),
    .en          (io.en),
    .offset      (offset),
    .ramp_k      (ramp_k),
    .echo_active (echo_active)
  );

  always_comb begin
    // Subtracting midscale from an unsigned sample is just an MSB flip plus sign extension.
    s    = {~mic_q[DATA_W-1], ~mic_q[DATA_W-1], mic_q[DATA_W-2:0]};
    e    = {~io.delayed_signal[DATA_W-1], ~io.delayed_signal[DATA_W-1],
            io.delayed_signal[DATA_W-2:0]};
    e_x  = {{4{e[DATA_W]}}, e};
    k_x  = {{(DATA_W + 1){1'b0}}, k_q};
    prod = e_x * k_x;
    t    = (prod >>> 3) >>> mix_gain;
    if (bypass) t = '0;
    sum  = {{4{s[DATA_W]}}, s} + t;
    if (sum > HI)      mix_nxt = {1'b1, {(DATA_W - 1){1'b1}}};
    else if (sum < LO) mix_nxt = '0;
    else               mix_nxt = {~sum[DATA_W-1], sum[DATA_W-2:0]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mic_q   <= '0;
      k_q     <= '0;
      en_d1   <= 1'b0;
      valid_q <= 1'b0;
      mix_q   <= {1'b1, {(DATA_W - 1){1'b0}}};
    end else begin
      en_d1   <= io.en;
      valid_q <= en_d1;
      if (io.en) begin
        mic_q <= io.mic_signal;
        k_q   <= ramp_k;
      end
      if (en_d1) mix_q <= mix_nxt;
    end
  end

  assign io.mix_out   = mix_q;
  assign io.out_valid = valid_q;

endmodule

// File: tb/tb_echo_mixer.sv
// tb/tb_echo_mixer.sv - scoreboard bench for echo_mixer against a behavioural echo model
module tb_echo_mixer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [8:0] offset;
  logic [1:0] mix_gain;
  logic       bypass;
  logic       echo_active;

  always #5 clk = ~clk;

  echo_mixer_if #(.DATA_W(8)) io ();

  echo_mixer #(.DATA_W(8), .ADDR_W(9), .RAMP_LOG2(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .io          (io.slave),
    .offset      (offset),
    .mix_gain    (mix_gain),
    .bypass      (bypass),
    .echo_active (echo_active)
  );

  typedef struct {int tag; int val;} exp_t;
  exp_t q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit started = 0;

  // model: phase 0=muted/filling, 1=fading in, 2=full echo
  int m_ph, m_seen, m_rc, m_offq;
  bit pend;
  int pend_mic, pend_k;
  int cur_off;

  task automatic check(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d want %0d", name, cyc, act, req);
    end
  endtask

  function automatic int mdl_k();
    if (m_ph == 0) return 0;
    if (m_ph == 1) return m_rc / 4;
    return 8;
  endfunction

  function automatic int mix_ref(int mic, int dly, int k, int g, bit byp);
    int s, e, t;
    s = mic - 128;
    e = dly - 128;
    t = (e * k) >>> 3;
    t = t >>> g;
    if (byp) t = 0;
    s = s + t;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return s + 128;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_seen = 0; m_rc = 0; m_offq = 0; pend = 0;
  endtask

  task automatic step(bit e, int mic, int dly, int g, bit byp, int off);
    int n_ph, n_seen, n_rc;
    io.en             = e;
    io.mic_signal     = 8'(mic);
    io.delayed_signal = 8'(dly);
    mix_gain          = 2'(g);
    bypass            = byp;
    offset            = 9'(off);
    cur_off           = off;
    n_ph = m_ph; n_seen = m_seen; n_rc = m_rc;
    if (rst) begin
      if (pend) q.push_back('{cyc + 1, mix_ref(pend_mic, dly, pend_k, g, byp)});
      if (off != m_offq) begin
        n_ph = 0; n_seen = 0; n_rc = 0;
      end else if (e) begin
        if (m_ph == 0) begin
          n_seen = (m_seen < 511) ? m_seen + 1 : 511;
          if (n_seen >= off) begin n_ph = 1; n_rc = 0; end
        end else if (m_ph == 1) begin
          n_rc = m_rc + 1;
          if (n_rc == 32) n_ph = 2;
        end
      end
      if (e) begin pend_mic = mic; pend_k = mdl_k(); end
      pend = e;
    end
    @(posedge clk);
    cyc++;
    #1;
    if (rst) begin
      m_ph = n_ph; m_seen = n_seen; m_rc = n_rc; m_offq = off;
    end else begin
      model_reset();
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      exp_t x;
      check("echo_active", int'(echo_active), (m_ph != 0) ? 1 : 0);
      if (io.out_valid) begin
        if (q.size() == 0) begin
          check("unexpected_valid", int'(io.out_valid), 0);
        end else begin
          x = q.pop_front();
          check("latency", cyc, x.tag);
          check("mix_out", int'(io.mix_out), x.val);
        end
      end else if (q.size() > 0 && q[0].tag <= cyc) begin
        check("missing_valid", int'(io.out_valid), 1);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    int dm[5], dd[5], dg[5], db[5];
    io.en = 0; io.mic_signal = 0; io.delayed_signal = 0;
    offset = 9'd4; mix_gain = 0; bypass = 0; cur_off = 4;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_mix_out", int'(io.mix_out), 128);
    check("reset_out_valid", int'(io.out_valid), 0);
    check("reset_echo_active", int'(echo_active), 0);
    rst = 1'b1;
    started = 1;

    // fill with offset 4, then full fade-in profile with a max-scale echo
    step(0, 0, 0, 0, 0, 4);
    for (int i = 0; i < 60; i++) step(1, (i < 4) ? 200 : 128, 255, 0, 0, 4);

    dm = '{128, 128, 250, 5, 77};
    dd = '{192, 192, 250, 5, 10};
    dg = '{0, 2, 0, 0, 0};
    db = '{0, 0, 0, 0, 1};
    for (int i = 0; i < 5; i++) begin
      step(1, dm[i], 0, 0, 0, 4);
      step(0, 0, dd[i], dg[i], db[i] != 0, 4);
    end

    // retune while idle, then run back-to-back through refill and ramp
    step(0, 0, 0, 0, 0, 6);
    for (int i = 0; i < 80; i++)
      step(1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3), 0, 6);

    for (int i = 0; i < 1500; i++) begin
      int off;
      off = cur_off;
      if ($urandom_range(0, 99) == 0) off = $urandom_range(0, 12);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 255), $urandom_range(0, 255),
           $urandom_range(0, 3), $urandom_range(0, 7) == 0, off);
    end

    for (int i = 0; i < 45; i++)
      step(1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3), 0, 0);
    for (int i = 0; i < 560; i++)
      step(1, $urandom_range(0, 255), $urandom_range(0, 255), 0, 0, 511);

    // reset landing between en and out_valid
    repeat (3) step(0, 0, 0, 0, 0, 511);
    step(1, 20, 0, 0, 0, 511);
    #1;
    rst = 1'b0;
    #1;
    check("async_reset_mix_out", int'(io.mix_out), 128);
    check("async_reset_out_valid", int'(io.out_valid), 0);
    check("async_reset_echo_active", int'(echo_active), 0);
    model_reset();
    q.delete();
    step(0, 0, 0, 0, 0, 3);
    rst = 1'b1;
    repeat (4) step(0, 0, 0, 0, 0, 3);
    for (int i = 0; i < 60; i++)
      step(1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3), i >= 50, 3);

    repeat (4) step(0, 0, 0, 0, 0, 3);
    check("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
